// File: rtl/serial_rom_loader.sv
// UART-fed program loader: parses a framed image upload (sync, count, words, checksum),
// writes each word into the instruction ROM and answers the host with ACK or NAK.
module serial_rom_loader #(
  parameter int          ADDR_WIDTH     = 15,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  recv_error,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_data,
  output logic                  loading,
  output logic                  done,
  output logic                  error
);

  localparam int          IDXW      = ADDR_WIDTH + 1;
  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [63:0] MAX_WORDS = 64'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [15:0]     count_r;
  logic [7:0]      hi_r;
  logic [IDXW-1:0] index_r;
  logic [7:0]      sum_r;
  logic [TW-1:0]   tcnt_r;
  logic            ack_r;

  logic            in_frame_s;
  logic            take_s;
  logic            timeout_s;
  logic            pass_s;
  logic            fail_s;
  logic [15:0]     full_count_s;
  logic [IDXW-1:0] next_index_s;

  // A byte is consumed only when no framing error accompanies the strobe.
  assign in_frame_s   = (state_r != IDLE) && (state_r != RESP);
  assign take_s       = received && !recv_error;
  assign timeout_s    = in_frame_s && !received && (tcnt_r == TW'(TIMEOUT_CYCLES));
  assign full_count_s = {count_r[15:8], rx_byte};
  assign next_index_s = index_r + {{(IDXW-1){1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and frame verdict
  always_comb begin
    next_state_s = state_r;
    pass_s       = 1'b0;
    fail_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (take_s && (rx_byte == SYNC_BYTE)) next_state_s = CNT_HI;
        else                                  next_state_s = IDLE;
      end
      CNT_HI: begin
        if (take_s) next_state_s = CNT_LO;
        else        next_state_s = CNT_HI;
      end
      CNT_LO: begin
        if (!take_s)                              next_state_s = CNT_LO;
        else if (full_count_s == 16'd0)           next_state_s = CHECK;
        else if (64'(full_count_s) > MAX_WORDS)   fail_s       = 1'b1;
        else                                      next_state_s = DATA_HI;
      end
      DATA_HI: begin
        if (take_s) next_state_s = DATA_LO;
        else        next_state_s = DATA_HI;
      end
      DATA_LO: begin
        if (!take_s)                                   next_state_s = DATA_LO;
        else if (64'(next_index_s) == 64'(count_r))    next_state_s = CHECK;
        else                                           next_state_s = DATA_HI;
      end
      CHECK: begin
        if (!take_s)                 next_state_s = CHECK;
        else if (rx_byte == sum_r)   pass_s       = 1'b1;
        else                         fail_s       = 1'b1;
      end
      RESP: begin
        if (!is_transmitting) next_state_s = IDLE;
        else                  next_state_s = RESP;
      end
      default: next_state_s = IDLE;
    endcase
    // Line errors and stalls override whatever the byte decode decided.
    if (in_frame_s && (recv_error || timeout_s)) begin
      pass_s = 1'b0;
      fail_s = 1'b1;
    end else begin
      fail_s = fail_s;
    end
    if (pass_s || fail_s) next_state_s = RESP;
    else                  next_state_s = next_state_s;
  end

  // Datapath: count/word capture, checksum, timeout and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= 16'd0;
      hi_r     <= 8'd0;
      index_r  <= '0;
      sum_r    <= 8'd0;
      tcnt_r   <= '0;
      ack_r    <= 1'b0;
      transmit <= 1'b0;
      tx_byte  <= 8'd0;
      rom_we   <= 1'b0;
      rom_addr <= '0;
      rom_data <= 16'd0;
      loading  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      rom_we   <= 1'b0;
      transmit <= 1'b0;
      if (in_frame_s && !received) tcnt_r <= tcnt_r + TW'(1);
      else                         tcnt_r <= '0;
      if (pass_s || fail_s) ack_r <= pass_s;
      case (state_r)
        IDLE: begin
          if (take_s && (rx_byte == SYNC_BYTE)) begin
            done    <= 1'b0;
            error   <= 1'b0;
            sum_r   <= 8'd0;
            loading <= 1'b1;
          end
        end
        CNT_HI: begin
          if (take_s) begin
            count_r[15:8] <= rx_byte;
            sum_r         <= sum_r + rx_byte;
          end
        end
        CNT_LO: begin
          if (take_s) begin
            count_r[7:0] <= rx_byte;
            sum_r        <= sum_r + rx_byte;
            index_r      <= '0;
          end
        end
        DATA_HI: begin
          if (take_s) begin
            hi_r  <= rx_byte;
            sum_r <= sum_r + rx_byte;
          end
        end
        DATA_LO: begin
          if (take_s) begin
            rom_we   <= 1'b1;
            rom_addr <= index_r[ADDR_WIDTH-1:0];
            rom_data <= {hi_r, rx_byte};
            index_r  <= next_index_s;
            sum_r    <= sum_r + rx_byte;
          end
        end
        RESP: begin
          if (!is_transmitting) begin
            transmit <= 1'b1;
            tx_byte  <= ack_r ? ACK_BYTE : NAK_BYTE;
            loading  <= 1'b0;
            done     <= ack_r;
            error    <= !ack_r;
          end
        end
        default: begin
          loading <= loading;
        end
      endcase
    end
  end

endmodule
